// File: rtl/onchip_mem_loader_pkg.sv
// onchip_mem_loader_pkg: shared types and constants for the on-chip memory loader
package onchip_mem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, DRAIN, DONE} state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/onchip_mem_loader_byte_packer.sv
// byte_packer: assembles four stream bytes little-endian into one 32-bit word
module byte_packer
  import onchip_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  always_comb begin
    word_d = word_q;
    if (in_valid) word_d[{cnt_q, 3'b000} +: 8] = in_data;
    cnt_d = clear ? 2'd0 : in_valid ? cnt_q + 2'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end
  assign word       = word_q;
  assign word_valid = in_valid && cnt_q == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/onchip_mem_loader.sv
// onchip_mem_loader: streams bytes into on-chip memory, then reads back and checks a sum
module onchip_mem_loader
  import onchip_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);
  localparam logic [ADDR_W:0] MAX_W = (ADDR_W + 1)'(DEPTH);
  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_idx;
  logic [31:0]     wsum_q, wsum_d, rsum_q, rsum_d, checksum_q, checksum_d, word;
  logic            bad_q, bad_d, pend_q, pend_d, error_q, error_d, clear, word_valid;
  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (s_valid && s_ready),
    .in_data   (s_data),
    .word      (word),
    .word_valid(word_valid)
  );
  assign clear    = state_q == IDLE && start;
  assign last_idx = cnt_q - {{ADDR_W{1'b0}}, 1'b1};
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;
    bad_d      = bad_q;
    pend_d     = 1'b0;
    error_d    = error_q;
    checksum_d = checksum_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d    = word_count;
        wr_ptr_d = '0;
        wsum_d   = '0;
        rsum_d   = '0;
        error_d  = 1'b0;
        bad_d    = word_count > MAX_W;
        // Empty and oversized runs skip all memory traffic but keep the two-cycle completion
        state_d  = (word_count == '0 || word_count > MAX_W) ? DRAIN : LOAD;
      end
      LOAD: state_d = word_valid ? WRITE : LOAD;
      WRITE: begin
        wsum_d   = wsum_q + word;
        rd_ptr_d = '0;
        wr_ptr_d = wr_ptr_q == last_idx ? wr_ptr_q : wr_ptr_q + 1'b1;
        state_d  = wr_ptr_q == last_idx ? VERIFY : LOAD;
      end
      VERIFY: begin
        pend_d   = 1'b1;
        rsum_d   = rsum_q + (pend_q ? mem_readdata : 32'h0);
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = rd_ptr_q == last_idx ? DRAIN : VERIFY;
      end
      DRAIN: begin
        rsum_d     = rsum_q + (pend_q ? mem_readdata : 32'h0);
        error_d    = bad_q || wsum_q != rsum_d;
        checksum_d = wsum_q;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      bad_q      <= 1'b0;
      pend_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
      bad_q      <= bad_d;
      pend_q     <= pend_d;
      error_q    <= error_d;
      checksum_q <= checksum_d;
    end
  end
  assign s_ready        = state_q == LOAD;
  assign mem_chipselect = state_q == WRITE || state_q == VERIFY;
  assign mem_write      = state_q == WRITE;
  assign mem_address    = state_q == WRITE ? wr_ptr_q[ADDR_W-1:0] :
                          state_q == VERIFY ? rd_ptr_q[ADDR_W-1:0] : '0;
  assign mem_byteenable = mem_chipselect ? BE_ALL : 4'h0;
  assign mem_writedata  = word;
  assign mem_clken      = ~reset;
  assign busy           = state_q != IDLE;
  assign done           = state_q == DONE;
  assign error          = error_q;
  assign checksum       = checksum_q;
endmodule

// File: doc/onchip_mem_loader.md
# onchip_mem_loader

Upstream fill engine for the 1024×32 single-port on-chip memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them sequentially from address 0 over the memory's Avalon slave signals. It then reads the region back, compares a 32-bit additive checksum against the written data, and reports completion and status. Sits between the host byte source (UART/JTAG bridge) and the memory's s1 port; the memory must not see other masters while `busy` is high.

## Interface
- `ADDR_W`, 10, memory word-address width
- `DEPTH`, 1024, memory depth in words; must equal 2**ADDR_W

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE
- `word_count`  in  ADDR_W+1  number of words to load; latched on accepted `start`
- `s_data`  in  8  stream byte
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  loader accepts a byte this cycle
- `mem_address`  out  ADDR_W  word address to memory
- `mem_byteenable`  out  4  always 4'hF when `mem_chipselect` is high, else 4'h0
- `mem_chipselect`  out  1  memory access this cycle
- `mem_write`  out  1  write strobe; high only together with `mem_chipselect`
- `mem_writedata`  out  32  packed word
- `mem_clken`  out  1  memory clock enable; 0 in reset, 1 otherwise
- `mem_readdata`  in  32  memory read data; valid the cycle after the address is presented
- `busy`  out  1  high from accepted `start` until the `done` cycle, inclusive
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  status of the last run; valid from `done` until the next accepted `start`
- `checksum`  out  32  sum mod 2^32 of the words written in the last run

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, DRAIN, DONE.
- IDLE: `s_ready`=0. On `start`, latch `word_count`, clear `wr_ptr`, the byte counter, both accumulators and `error`, then go to LOAD.
  - `word_count`=0: go directly to DONE with `error`=0 and `checksum`=0.
  - `word_count`>DEPTH: go directly to DONE with `error`=1 and no memory access.
- LOAD: `s_ready`=1. Each handshake (`s_valid & s_ready`) stores byte k (k=0..3) into bits [8k+7:8k]. After byte 3 is accepted, go to WRITE.
- WRITE: one cycle. Drive `s_ready`=0, `mem_chipselect`=`mem_write`=1, `mem_address`=`wr_ptr`, `mem_writedata`=the packed word. Add the word to `wsum`.
  - If `wr_ptr`=`word_count`-1, go to VERIFY with `rd_ptr`=0.
  - Otherwise increment `wr_ptr` and return to LOAD.
- VERIFY: `mem_chipselect`=1, `mem_write`=0, `mem_address`=`rd_ptr`, and `rd_ptr` increments every cycle. Each cycle after an address was issued, add `mem_readdata` to `rsum`. After issuing address `word_count`-1, go to DRAIN.
- DRAIN: one cycle. Capture the final read word; no access.
- DONE: `done`=1, `error`=(`wsum`≠`rsum`), `checksum`=`wsum`. Next state is IDLE.
- `start` outside IDLE is ignored.
- A partial word at stream stall is held indefinitely; there is no timeout.
- Accumulators are 32-bit and wrap modulo 2^32. Pointers never wrap within a run, because `word_count`≤DEPTH.

## Timing
- Reset values: `s_ready`, `mem_*` outputs, `busy`, `done` and `error` all 0; `checksum`=0; state IDLE.
- Reset mid-run: next cycle is IDLE with all outputs at reset values. Memory contents already written are left as is.
- `start` → first `s_ready`=1: 1 cycle.
- Per word: at least 5 cycles (4 bytes + WRITE). `s_ready` drops for exactly the WRITE cycle.
- Verify phase: N address cycles + 1 DRAIN cycle. `done` follows DRAIN by 1 cycle.
- Minimum run for N words: 1 + 5N + N + 1 + 1 cycles.
- `done` and `busy` are both high in the DONE cycle. `busy`=0 on the following cycle.

## Structure
- Package `onchip_mem_loader_pkg` holds:
  - the state enum;
  - `BYTES_PER_WORD`=4;
  - `BE_ALL`=4'hF.
- Sub-module `byte_packer`: 8→32 little-endian assembler. It has the byte counter, a `word_valid` pulse and a `clear` input. The FSM and the checksum logic stay in the top level.

## Test plan
- `word_count`=2, bytes 01 02 03 04 05 06 07 08, `s_valid` always high → writes 0x04030201 @0 and 0x08070605 @1; `checksum`=0x0C0A0806; `error`=0; `done` 14 cycles after `start`.
- `word_count`=1 with random `s_valid` gaps of 0–5 cycles → same data in memory; no byte lost or duplicated; `s_ready`=0 only in the WRITE cycle.
- Memory model corrupts the readback of address 0 by XOR 0x1 → `error`=1 at `done`; `checksum` still equals the written sum.
- `word_count`=0 → `done` 2 cycles after `start`, `error`=0, no `mem_chipselect`. `word_count`=1025 → `done`, `error`=1, no access.
- `word_count`=1024 with bytes FF FF FF FF repeated → `checksum`=0xFFFFFC00 (wrap); last write at address 1023; readback covers addresses 0..1023.
- `reset` asserted during LOAD after 2 bytes → next cycle IDLE with all outputs 0. A new `start` with `word_count`=1 then loads cleanly from byte 0.
